// File: rtl/vtg_pkg.sv
// vtg_pkg: shared timing constants and delay-line record for video_timing_gen.
// 1280x1024@60 raster: line total 1688 pixels, frame total 1066 lines.
// Optional macro VTG_TEST_PATTERN_EN adds a 3-bit colour-bar index to the
// delay-line record.
package vtg_pkg;

  localparam logic [10:0] H_ACTIVE = 11'd1280;
  localparam logic [10:0] H_FP     = 11'd48;
  localparam logic [10:0] H_SYNC   = 11'd112;
  localparam logic [10:0] H_BP     = 11'd248;
  localparam logic [10:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [10:0] HS_START = H_ACTIVE + H_FP;
  localparam logic [10:0] HS_END   = HS_START + H_SYNC - 11'd1;

  localparam logic [10:0] V_ACTIVE = 11'd1024;
  localparam logic [10:0] V_FP     = 11'd1;
  localparam logic [10:0] V_SYNC   = 11'd3;
  localparam logic [10:0] V_BP     = 11'd38;
  localparam logic [10:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] VS_START = V_ACTIVE + V_FP;
  localparam logic [10:0] VS_END   = VS_START + V_SYNC - 11'd1;

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [10:0] BAR_WIDTH = 11'd160;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [2:0] bar;
  } dl_rec_t;

  localparam dl_rec_t DL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, bar: 3'd0};

  // Bar index bits {r,g,b} each expand to a full-scale or zero channel.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction
`else
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } dl_rec_t;

  localparam dl_rec_t DL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};
`endif

  localparam int unsigned DL_W = $bits(dl_rec_t);

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: bundle between the timing generator, the wave display
// and the DVI/VGA pins.
//   master (timing gen): drives x, y, valid, vsync and the aligned outputs;
//                        receives pix_en and the display's r_in/g_in/b_in.
//   slave  (environment): the opposite directions.
// Macro VTG_TEST_PATTERN_EN adds tp_sel (colour-bar select).
interface video_timing_gen_if;
  logic        pix_en;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        vsync;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;
`ifdef VTG_TEST_PATTERN_EN
  logic        tp_sel;
`endif

  modport master (
`ifdef VTG_TEST_PATTERN_EN
    input  tp_sel,
`endif
    input  pix_en, r_in, g_in, b_in,
    output x, y, valid, vsync, hsync_out, vsync_out, de_out, r_out, g_out, b_out
  );

  modport slave (
`ifdef VTG_TEST_PATTERN_EN
    output tp_sel,
`endif
    output pix_en, r_in, g_in, b_in,
    input  x, y, valid, vsync, hsync_out, vsync_out, de_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/vtg_delay_line.sv
// vtg_delay_line: enable-gated shift register, WIDTH bits by DEPTH stages.
// Ports: clk, rst (async, active-high), i_en (shift enable), i_rst_val
// (value loaded into every stage on reset), i_d (input), o_q (output).
// DEPTH=0 is a combinational pass-through.
module vtg_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    assign o_q = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= i_rst_val;
      end else if (i_en) begin
        r_sr[0] <= i_d;
        for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    end

    assign o_q = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: 1280x1024@60 raster timing and output re-alignment.
// Ports:
//   clk    system clock; all state advances only on bus.pix_en
//   reset  asynchronous, active-high
//   bus    video_timing_gen_if.master: x/y/valid/vsync to the wave display,
//          r_in/g_in/b_in back from it, aligned hsync_out/vsync_out/de_out
//          and blanked r_out/g_out/b_out to the pins.
// Parameter DISPLAY_LATENCY (0..7): strobes from x/y to the matching r_in.
// Macro VTG_TEST_PATTERN_EN: tp_sel replaces rgb with 8 vertical colour bars.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned DISPLAY_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  video_timing_gen_if.master        bus
);

  logic [10:0] r_h, r_v;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_valid, r_hs, r_vs;
  logic        r_hso, r_vso, r_de;
  logic [7:0]  r_r, r_g, r_b;
  dl_rec_t     w_dl_in, w_dl_out;
  logic [23:0] w_rgb_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (bus.pix_en) begin
      if (r_h == H_TOTAL - 11'd1) begin
        r_h <= '0;
        r_v <= (r_v == V_TOTAL - 11'd1) ? '0 : r_v + 11'd1;
      end else begin
        r_h <= r_h + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
    end else if (bus.pix_en) begin
      r_x     <= r_h;
      r_y     <= r_v[9:0];
      r_valid <= (r_h < H_ACTIVE) && (r_v < V_ACTIVE);
      r_hs    <= !((r_h >= HS_START) && (r_h <= HS_END));
      r_vs    <= !((r_v >= VS_START) && (r_v <= VS_END));
    end
  end

  assign w_dl_in.hsync = r_hs;
  assign w_dl_in.vsync = r_vs;
  assign w_dl_in.de    = r_valid;
`ifdef VTG_TEST_PATTERN_EN
  assign w_dl_in.bar   = 3'(r_x / BAR_WIDTH);
`endif

  vtg_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (DISPLAY_LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst       (reset),
    .i_en      (bus.pix_en),
    .i_rst_val (DL_IDLE),
    .i_d       (w_dl_in),
    .o_q       (w_dl_out)
  );

`ifdef VTG_TEST_PATTERN_EN
  assign w_rgb_src = bus.tp_sel ? bar_rgb(w_dl_out.bar) : {bus.r_in, bus.g_in, bus.b_in};
`else
  assign w_rgb_src = {bus.r_in, bus.g_in, bus.b_in};
`endif

  // Output register pairs the delayed sync/de with the display's colour,
  // which arrives DISPLAY_LATENCY strobes after its x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hso <= 1'b1;
      r_vso <= 1'b1;
      r_de  <= 1'b0;
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
    end else if (bus.pix_en) begin
      r_hso <= w_dl_out.hsync;
      r_vso <= w_dl_out.vsync;
      r_de  <= w_dl_out.de;
      {r_r, r_g, r_b} <= w_dl_out.de ? w_rgb_src : '0;
    end
  end

  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.valid     = r_valid;
  assign bus.vsync     = r_vs;
  assign bus.hsync_out = r_hso;
  assign bus.vsync_out = r_vso;
  assign bus.de_out    = r_de;
  assign bus.r_out     = r_r;
  assign bus.g_out     = r_g;
  assign bus.b_out     = r_b;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen. Expected values come from a raster
// position model: after strobe s since reset, x/y reflect position s-1 and the
// aligned outputs reflect position s-LAT-2. The bench plays the wave display,
// returning r_in=8'hAA (8'h55 marker at x=5) LAT strobes after each x.
module tb_video_timing_gen;
  localparam int LAT = 2;
  localparam int HT  = 1688;
  localparam int VT  = 1066;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  video_timing_gen_if bus ();

  video_timing_gen #(.DISPLAY_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, valid, vsync, hso, vso, de, r, g, b;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   s          = 0;   // pix_en strobes since reset release

  function automatic int hx(int p);
    return p % HT;
  endfunction

  function automatic int ln(int p);
    return (p / HT) % VT;
  endfunction

  function automatic int active(int p);
    return (hx(p) < 1280 && ln(p) < 1024) ? 1 : 0;
  endfunction

  function automatic int color_r(int p);
    return (p >= 0 && hx(p) == 5) ? 'h55 : 'hAA;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int p1 = s - 1;
    int po = s - LAT - 2;
    if (s == 0) begin
      e.x = 0; e.y = 0; e.valid = 0; e.vsync = 1;
    end else begin
      e.x     = hx(p1);
      e.y     = ln(p1) % 1024;
      e.valid = active(p1);
      e.vsync = (ln(p1) >= 1025 && ln(p1) <= 1027) ? 0 : 1;
    end
    if (po < 0) begin
      e.hso = 1; e.vso = 1; e.de = 0; e.r = 0; e.g = 0; e.b = 0;
    end else begin
      e.hso = (hx(po) >= 1328 && hx(po) <= 1439) ? 0 : 1;
      e.vso = (ln(po) >= 1025 && ln(po) <= 1027) ? 0 : 1;
      e.de  = active(po);
      e.r   = e.de ? color_r(po) : 0;
      e.g   = e.de ? 'h0F : 0;
      e.b   = e.de ? 'hC3 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s at t=%0t s=%0d: got %0d expected %0d", nm, $time, s, act, exp_v);
    end
  endtask

  // Colour the display returns now is consumed at the next strobe.
  task automatic drive_rgb();
    bus.r_in = 8'(color_r(s - LAT - 1));
    bus.g_in = 8'h0F;
    bus.b_in = 8'hC3;
  endtask

  task automatic cycle(input bit en);
    bus.pix_en = en;
    @(posedge clk);
    #2;
    if (en) s++;
    q.push_back(expect_now());
    drive_rgb();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    reset      = 1'b1;
    bus.pix_en = 1'b1;
    s          = 0;
    #1;
    chk("rst_async_x",     int'(bus.x), 0);
    chk("rst_async_valid", int'(bus.valid), 0);
    chk("rst_async_vsync", int'(bus.vsync), 1);
    chk("rst_async_hso",   int'(bus.hsync_out), 1);
    chk("rst_async_vso",   int'(bus.vsync_out), 1);
    chk("rst_async_de",    int'(bus.de_out), 0);
    chk("rst_async_r",     int'(bus.r_out), 0);
    repeat (n) begin
      @(posedge clk);
      #2;
      q.push_back(expect_now());
    end
    drive_rgb();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("x",         int'(bus.x),         e.x);
      chk("y",         int'(bus.y),         e.y);
      chk("valid",     int'(bus.valid),     e.valid);
      chk("vsync",     int'(bus.vsync),     e.vsync);
      chk("hsync_out", int'(bus.hsync_out), e.hso);
      chk("vsync_out", int'(bus.vsync_out), e.vso);
      chk("de_out",    int'(bus.de_out),    e.de);
      chk("r_out",     int'(bus.r_out),     e.r);
      chk("g_out",     int'(bus.g_out),     e.g);
      chk("b_out",     int'(bus.b_out),     e.b);
    end
  end

  initial begin
`ifdef VTG_TEST_PATTERN_EN
    bus.tp_sel = 1'b0;
`endif
    bus.pix_en = 1'b0;
    drive_rgb();
    do_reset(3);

    // Two full lines plus: active edge 1279/1280, hsync window, marker at x=5.
    repeat (2 * HT + 100) cycle(1'b1);

    // Irregular strobes: sequence must continue without skips, holding between.
    repeat (4000) cycle(1'($urandom_range(0, 1)));

    // Run to x=600 and reset mid-line; restart must begin cleanly at (0,0).
    begin
      int guard = 0;
      while (hx(s - 1) != 600 && guard < HT) begin
        cycle(1'b1);
        guard++;
      end
    end
    do_reset(2);
    repeat (2 * HT) cycle(1'b1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates 1280x1024@60 raster timing for the waveform display path. Outputs pixel coordinates `x`, `y`, `valid` and `vsync` to the wave display top.
- Takes back the display's `r`/`g`/`b` and re-aligns it with delayed, blanked sync for the DVI/VGA output pins.
- Sits directly downstream of, and wraps around, the wave display stage.
- Counters advance only on the pixel strobe, so the block runs on the system clock.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 112, hsync pulse width (pixels)
- H_BP, 248, horizontal back porch; line total 1688
- V_ACTIVE, 1024, active lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 38, vertical back porch; frame total 1066
- DISPLAY_LATENCY, 2, pixel strobes from `x`/`y` presentation to matching `r_in`/`g_in`/`b_in`; range 0..7

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel strobe; all state advances only when 1
- x  out  11  horizontal counter; 0..1279 in active region
- y  out  10  vertical counter bits [9:0]; 0..1023 in active region
- valid  out  1  x/y inside active region
- vsync  out  1  active-low vertical sync, undelayed; feeds display idle detect
- r_in, g_in, b_in  in  8 each  pixel colour from wave display
- hsync_out  out  1  active-low hsync, aligned to rgb_out
- vsync_out  out  1  active-low vsync, aligned to rgb_out
- de_out  out  1  data enable, aligned to rgb_out
- r_out, g_out, b_out  out  8 each  blanked, aligned colour

Behaviour:
- Counters: h_cnt 11b (0..1687), v_cnt 11b (0..1065).
  - On pix_en, h_cnt increments. At 1687 it wraps to 0 and v_cnt increments.
  - At h=1687 and v=1065 both counters wrap to 0.
  - pix_en=0: counters and every output register hold.
- Stage-1 registers load on pix_en from the current counters, giving 1 strobe latency:
  - x = h_cnt.
  - y = v_cnt[9:0]; truncated, meaningful only when valid.
  - valid = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 1328..1439.
  - vsync low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 1025..1027, over whole lines.
- Delay line: {hsync, vsync, valid} pass through a DISPLAY_LATENCY-deep shift register gated by pix_en, then one output register.
  - The output register also captures r_in/g_in/b_in.
  - rgb_out = de ? rgb_in : 0.
  - Output alignment: r_in sampled DISPLAY_LATENCY strobes after the matching x is output.
- Reset, asynchronous:
  - Counters = 0; x=0, y=0, valid=0.
  - vsync=1, hsync_out=1, vsync_out=1.
  - de_out=0; rgb_out=0; delay line cleared to the inactive value {1,1,0}.
- First pix_en after reset release: x=0, y=0, valid=1.
- Reset mid-frame restarts at (0,0) with no partial sync pulse emitted.
- Reset is asserted asynchronously and deasserted externally synchronized.

Optional Feature:
- Macro: VTG_TEST_PATTERN_EN.
- Defined: adds input `tp_sel` (1b).
  - When tp_sel=1, rgb_in is replaced at the output register by 8 vertical colour bars, 160 px wide.
  - The bar index comes from the delayed x[10:7]/… path: 3 bits of x/160, carried through the delay line.
  - Bar colour index 0..7 maps to {r,g,b} = {idx[2],idx[1],idx[0]} each replicated to 8'hFF/8'h00.
- Undefined: no `tp_sel` port, no x delay bits; colour path purely rgb_in.

Decomposition:
- Package vtg_pkg holds:
  - the timing constants (H_TOTAL=1688, V_TOTAL=1066, sync start/end derived values);
  - the delay-line record layout {hsync,vsync,de[,bar]} width constant.
- One natural sub-module: vtg_delay_line. It is a parameterized-width, parameterized-depth, enable-gated shift register with reset value input; depth 0 is a pass-through.

Test Plan:
- Reset, then pix_en=1 continuously: first output x=0, y=0, valid=1; x reaches 1279 with valid=1, then valid=0 at x=1280.
- Horizontal sync: hsync (via vsync-undelayed line monitor) and hsync_out are low exactly 112 strobes. hsync_out falls DISPLAY_LATENCY+1 strobes after x=1328 is output.
- Frame wrap: after 1688*1066 strobes x/y return to 0/0. vsync is low for exactly 3*1688 strobes starting at line 1025.
- pix_en toggled 1-0-1 pseudo-randomly: x sequence identical to the continuous case, with no skipped or repeated values; outputs held when pix_en=0.
- rgb_in=8'hAA driven constantly: r_out=8'hAA only while de_out=1, and 0 during blanking. A marker injected at x=5 appears with de_out at the aligned strobe.
- Assert reset at x=600, y=300: all outputs take reset values immediately. After release the count restarts at 0,0 and no stray sync low appears.
